dmem_sized: RTL

- Parametrised data memory for the MIPS datapath, successor to the fixed 1024x32 word RAM.
- Adds byte-addressed MIPS load/store sizes (byte/half/word) with byte-lane writes and sign/zero extension on loads.
- Adds a valid/ready request handshake with configurable response latency, plus misalignment error reporting.
- Sits between the MEM stage and the backing RAM array.

---
 rtl/dmem_sized.sv | 137 +++++++++++++
 1 files changed

// File: rtl/dmem_sized.sv
// Sized byte/half/word data memory with valid/ready request handshake,
// configurable response latency and misalignment error reporting.
module dmem_sized #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [31:0]           req_wd,
  output logic                  resp_valid,
  output logic [31:0]           resp_rd,
  output logic                  resp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  state_e      state_q;
  logic [1:0]  cnt_q;
  logic        resp_valid_q;
  logic [31:0] resp_rd_q;
  logic        resp_err_q;
  logic [31:0] rd_pend_q;
  logic        err_pend_q;

  logic [31:0] mem_q [DEPTH] = '{default: '0};

  logic [1:0]            off;
  logic [ADDR_WIDTH-1:0] widx;
  logic                  accept;
  logic                  err_d;
  logic [3:0]            be_d;
  logic [31:0]           wdata_d;
  logic [31:0]           rword;
  logic [7:0]            rbyte;
  logic [15:0]           rhalf;
  logic [31:0]           rd_d;

  assign off       = req_addr[1:0];
  assign widx      = req_addr[ADDR_WIDTH+1:2];
  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready && !reset;
  assign rword     = mem_q[widx];
  assign rbyte     = rword[{off, 3'b000} +: 8];
  assign rhalf     = off[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    err_d   = 1'b0;
    be_d    = 4'b0000;
    wdata_d = req_wd;
    rd_d    = 32'h0;
    case (req_size)
      2'b00: begin
        be_d    = 4'b0001 << off;
        wdata_d = {4{req_wd[7:0]}};
        rd_d    = req_unsigned ? {24'h0, rbyte}
                               : {{24{rbyte[7]}}, rbyte};
      end
      2'b01: begin
        err_d   = off[0];
        be_d    = off[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{req_wd[15:0]}};
        rd_d    = req_unsigned ? {16'h0, rhalf}
                               : {{16{rhalf[15]}}, rhalf};
      end
      2'b10: begin
        err_d = (off != 2'b00);
        be_d  = 4'b1111;
        rd_d  = rword;
      end
      default: err_d = 1'b1;
    endcase
    if (err_d || req_we) rd_d = 32'h0;
  end

  // Array is deliberately left out of reset so stores survive it.
  always_ff @(posedge clock) begin
    if (accept && req_we && !err_d) begin
      for (int k = 0; k < 4; k++) begin
        if (be_d[k]) mem_q[widx][8*k +: 8] <= wdata_d[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      resp_valid_q <= 1'b0;
      resp_rd_q    <= 32'h0;
      resp_err_q   <= 1'b0;
      rd_pend_q    <= 32'h0;
      err_pend_q   <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_rd_q    <= 32'h0;
      resp_err_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            rd_pend_q  <= rd_d;
            err_pend_q <= err_d;
            cnt_q      <= 2'(LATENCY - 1);
            state_q    <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 2'd1;
          if (cnt_q == 2'd1) state_q <= RESP;
        end
        RESP: begin
          resp_valid_q <= 1'b1;
          resp_rd_q    <= rd_pend_q;
          resp_err_q   <= err_pend_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rd    = resp_rd_q;
  assign resp_err   = resp_err_q;

endmodule
